// File: rtl/timer_pkg.sv
// Shared constants for the 8-bit timer register block: address map, TCR/TSR bit positions,
// writable-bit masks and reset values.
`timescale 1ns/1ps
package timer_pkg;

  localparam logic [2:0] ADDR_TDR  = 3'd0;
  localparam logic [2:0] ADDR_TCR  = 3'd1;
  localparam logic [2:0] ADDR_TSR  = 3'd2;
  localparam logic [2:0] ADDR_TIER = 3'd3;
  localparam logic [2:0] ADDR_TCNT = 3'd4;

  localparam int TCR_LOAD      = 7;
  localparam int TCR_DW        = 5;
  localparam int TCR_EN        = 4;
  localparam int TCR_CLKSEL_HI = 1;
  localparam int TCR_CLKSEL_LO = 0;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  // Unimplemented bits are masked on write so they always read back as 0.
  localparam logic [7:0] TCR_MASK  = 8'hB3;
  localparam logic [7:0] TIER_MASK = 8'h03;

  localparam logic [7:0] TDR_RST  = 8'h00;
  localparam logic [7:0] TCR_RST  = 8'h00;
  localparam logic [1:0] TSR_RST  = 2'b00;
  localparam logic [7:0] TIER_RST = 8'h00;

  // Sticky flag update: an event in the same cycle beats a software clear.
  function automatic logic tsr_bit_next(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// APB access-phase timing: wait-state counter, pready/pslverr and the qualified
// read/write strobes used by the register file.
`timescale 1ns/1ps
module apb_wait_ctrl #(
  parameter int WAIT_STATES = 0
) (
  input  logic pclk,
  input  logic presetn,
  input  logic psel,
  input  logic penable,
  input  logic pwrite,
  input  logic acc_err,
  output logic pready,
  output logic pslverr,
  output logic wr_stb,
  output logic rd_stb
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  logic [2:0] wait_cnt_reg;
  logic       access;

  assign access  = psel & penable;
  assign pready  = access & (wait_cnt_reg == WS);
  assign pslverr = pready & acc_err;
  assign wr_stb  = pready & pwrite & ~acc_err;
  assign rd_stb  = access & ~pwrite & ~acc_err;

  // Counter is 0 in the first access cycle and parks at 0 between transfers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt_reg <= '0;
    end else if (!psel || pready) begin
      wait_cnt_reg <= '0;
    end else if (access) begin
      wait_cnt_reg <= wait_cnt_reg + 3'd1;
    end
  end

endmodule

// File: rtl/timer_apb_regs.sv
// APB register block for the 8-bit timer: TDR/TCR/TSR/TIER/TCNT decode, sticky
// overflow/underflow flags and the level timer interrupt.
`timescale 1ns/1ps
module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [7:0]        cnt_val,
  input  logic              ovf_evt,
  input  logic              udf_evt,
  output logic [7:0]        tdr,
  output logic              tcr_load,
  output logic              tcr_dw,
  output logic              tcr_en,
  output logic [1:0]        tcr_clksel,
  output logic              tmr_irq
);

  logic [7:0] tdr_reg;
  logic [7:0] tcr_reg;
  logic [7:0] tier_reg;
  logic [1:0] tsr_reg;
  logic [1:0] tsr_next;
  logic [1:0] evt;
  logic [2:0] reg_addr;
  logic       acc_err;
  logic       wr_stb;
  logic       rd_stb;
  logic       wr_tsr;
  logic [7:0] rdata_mux;

  assign reg_addr = paddr[2:0];
  // Any address above TCNT (including non-zero upper bits) errors, as does writing TCNT.
  assign acc_err  = (paddr > ADDR_W'(ADDR_TCNT)) |
                    (pwrite & (paddr == ADDR_W'(ADDR_TCNT)));

  apb_wait_ctrl #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_ctrl (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .acc_err (acc_err),
    .pready  (pready),
    .pslverr (pslverr),
    .wr_stb  (wr_stb),
    .rd_stb  (rd_stb)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tdr_reg  <= TDR_RST;
      tcr_reg  <= TCR_RST;
      tier_reg <= TIER_RST;
    end else if (wr_stb) begin
      case (reg_addr)
        ADDR_TDR:  tdr_reg  <= pwdata;
        ADDR_TCR:  tcr_reg  <= pwdata & TCR_MASK;
        ADDR_TIER: tier_reg <= pwdata & TIER_MASK;
        default:   ;
      endcase
    end
  end

  assign wr_tsr = wr_stb & (reg_addr == ADDR_TSR);
  assign evt[TSR_OVF] = ovf_evt;
  assign evt[TSR_UDF] = udf_evt;

  // Write-0-to-clear per flag; writing 1 leaves the flag alone.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_tsr
      assign tsr_next[gi] = tsr_bit_next(tsr_reg[gi], evt[gi], wr_tsr & ~pwdata[gi]);
    end
  endgenerate

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tsr_reg <= TSR_RST;
    end else begin
      tsr_reg <= tsr_next;
    end
  end

  always_comb begin
    rdata_mux = 8'h00;
    case (reg_addr)
      ADDR_TDR:  rdata_mux = tdr_reg;
      ADDR_TCR:  rdata_mux = tcr_reg;
      ADDR_TSR:  rdata_mux = {6'b0, tsr_reg};
      ADDR_TIER: rdata_mux = tier_reg;
      ADDR_TCNT: rdata_mux = cnt_val;
      default:   rdata_mux = 8'h00;
    endcase
  end

  assign prdata     = rd_stb ? rdata_mux : 8'h00;
  assign tdr        = tdr_reg;
  assign tcr_load   = tcr_reg[TCR_LOAD];
  assign tcr_dw     = tcr_reg[TCR_DW];
  assign tcr_en     = tcr_reg[TCR_EN];
  assign tcr_clksel = tcr_reg[TCR_CLKSEL_HI:TCR_CLKSEL_LO];
  assign tmr_irq    = |(tsr_reg & tier_reg[1:0]);

endmodule

// File: tb/tb_timer_apb_regs.sv
// Randomized APB bench for timer_apb_regs against a register-level reference model.
`timescale 1ns/1ps
module tb_timer_apb_regs;

  localparam int WS = 3;
  localparam int AW = 8;

  logic          pclk    = 1'b0;
  logic          presetn = 1'b1;
  logic          psel    = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite  = 1'b0;
  logic [AW-1:0] paddr   = '0;
  logic [7:0]    pwdata  = 8'h00;
  logic [7:0]    cnt_val = 8'h00;
  logic          ovf_evt = 1'b0;
  logic          udf_evt = 1'b0;
  logic [7:0]    prdata;
  logic          pready;
  logic          pslverr;
  logic [7:0]    tdr;
  logic          tcr_load;
  logic          tcr_dw;
  logic          tcr_en;
  logic [1:0]    tcr_clksel;
  logic          tmr_irq;

  timer_apb_regs #(
    .WAIT_STATES (WS),
    .ADDR_W      (AW)
  ) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .cnt_val    (cnt_val),
    .ovf_evt    (ovf_evt),
    .udf_evt    (udf_evt),
    .tdr        (tdr),
    .tcr_load   (tcr_load),
    .tcr_dw     (tcr_dw),
    .tcr_en     (tcr_en),
    .tcr_clksel (tcr_clksel),
    .tmr_irq    (tmr_irq)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural register contents.
  logic [7:0] m_tdr  = 8'h00;
  logic [7:0] m_tcr  = 8'h00;
  logic [7:0] m_tsr  = 8'h00;
  logic [7:0] m_tier = 8'h00;

  logic [7:0] rd_data;
  logic       rd_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic addr_err(input logic [AW-1:0] a, input logic w);
    return (a > 4) || (w && a == 4);
  endfunction

  function automatic logic [7:0] model_read(input logic [AW-1:0] a);
    case (a)
      0:       return m_tdr;
      1:       return m_tcr;
      2:       return m_tsr;
      3:       return m_tier;
      4:       return cnt_val;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_tdr = 8'h00; m_tcr = 8'h00; m_tsr = 8'h00; m_tier = 8'h00;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_tdr"},    tdr,        m_tdr);
    check({tag, "_load"},   tcr_load,   m_tcr[7]);
    check({tag, "_dw"},     tcr_dw,     m_tcr[5]);
    check({tag, "_en"},     tcr_en,     m_tcr[4]);
    check({tag, "_clksel"}, tcr_clksel, m_tcr[1:0]);
    check({tag, "_irq"},    tmr_irq,    ((m_tsr & m_tier) != 0));
    check({tag, "_idle_pready"}, pready, 1'b0);
    check({tag, "_idle_prdata"}, prdata, 8'h00);
  endtask

  // One APB transfer; evt is pulsed in the pready cycle so it lands on the completing edge.
  task automatic apb(input logic w, input logic [AW-1:0] a, input logic [7:0] d, input logic [1:0] evt);
    int waits = 0;
    logic ok = 1'b0;
    logic [7:0] exp_rd;
    logic exp_err;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1;
    while (1) begin
      waits++;
      if (pready === 1'b1) begin
        rd_data = prdata; rd_err = pslverr; ok = 1'b1;
        ovf_evt = evt[0]; udf_evt = evt[1];
        break;
      end
      if (waits >= 20) break;
      @(posedge pclk); #2;
    end
    exp_err = addr_err(a, w);
    exp_rd  = (w || exp_err) ? 8'h00 : model_read(a);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; ovf_evt = 1'b0; udf_evt = 1'b0;
    check("wait_cycles", waits, WS + 1);
    if (ok) begin
      check("pslverr", rd_err, exp_err);
      check("prdata", rd_data, exp_rd);
      if (w && !exp_err) begin
        case (a)
          0: m_tdr  = d;
          1: m_tcr  = d & 8'hB3;
          2: m_tsr  = m_tsr & (d | 8'hFC);
          3: m_tier = d & 8'h03;
          default: ;
        endcase
      end
      m_tsr = m_tsr | {6'b0, evt};
    end
    #1;
    check_outputs(w ? "wr" : "rd");
    $display("%0t %s addr=%02h data=%02h err=%0b waits=%0d evt=%0b", $time,
             w ? "WR" : "RD", a, w ? d : rd_data, rd_err, waits, evt);
  endtask

  task automatic pulse(input logic [1:0] evt);
    @(posedge pclk); #1;
    ovf_evt = evt[0]; udf_evt = evt[1];
    @(posedge pclk); #1;
    ovf_evt = 1'b0; udf_evt = 1'b0;
    m_tsr = m_tsr | {6'b0, evt};
    #1;
    check("pulse_irq", tmr_irq, ((m_tsr & m_tier) != 0));
    $display("%0t EVT ovf=%0b udf=%0b irq=%0b", $time, evt[0], evt[1], tmr_irq);
  endtask

  initial begin
    // Reset
    #2 presetn = 1'b0;
    #100;
    check("rst_pready", pready, 1'b0);
    check("rst_prdata", prdata, 8'h00);
    check("rst_pslverr", pslverr, 1'b0);
    check("rst_irq", tmr_irq, 1'b0);
    #100 presetn = 1'b1;
    cnt_val = 8'h3C;
    for (int i = 0; i < 5; i++) apb(1'b0, AW'(i), 8'h00, 2'b00);

    // Config
    apb(1'b1, 8'h00, 8'hFF, 2'b00);
    check("cfg_tdr", tdr, 8'hFF);
    apb(1'b1, 8'h01, 8'h80, 2'b00);
    check("cfg_load1", tcr_load, 1'b1);
    apb(1'b1, 8'h01, 8'h30, 2'b00);
    check("cfg_load0", tcr_load, 1'b0);
    check("cfg_dw_en", {tcr_dw, tcr_en, tcr_clksel}, 4'b1100);
    apb(1'b0, 8'h01, 8'h00, 2'b00);
    check("cfg_tcr_rd", rd_data, 8'h30);

    // Underflow / overflow flags
    pulse(2'b10);
    apb(1'b0, 8'h02, 8'h00, 2'b00);
    check("udf_rd", rd_data, 8'h02);
    apb(1'b1, 8'h02, 8'h00, 2'b00);
    apb(1'b0, 8'h02, 8'h00, 2'b00);
    check("udf_clr", rd_data, 8'h00);
    pulse(2'b01);
    apb(1'b0, 8'h02, 8'h00, 2'b00);
    check("ovf_rd", rd_data, 8'h01);

    // W0C and set-beats-clear
    pulse(2'b11);
    apb(1'b1, 8'h02, 8'h02, 2'b00);
    apb(1'b0, 8'h02, 8'h00, 2'b00);
    check("w0c_rd", rd_data, 8'h02);
    apb(1'b1, 8'h02, 8'h00, 2'b10);
    apb(1'b0, 8'h02, 8'h00, 2'b00);
    check("setwins_rd", rd_data, 8'h02);
    apb(1'b1, 8'h02, 8'h00, 2'b00);

    // Interrupt
    apb(1'b1, 8'h03, 8'h02, 2'b00);
    pulse(2'b10);
    check("irq_on", tmr_irq, 1'b1);
    apb(1'b1, 8'h02, 8'h00, 2'b00);
    check("irq_off", tmr_irq, 1'b0);
    apb(1'b1, 8'h03, 8'h01, 2'b00);
    pulse(2'b10);
    check("irq_masked", tmr_irq, 1'b0);
    apb(1'b1, 8'h02, 8'h00, 2'b00);

    // Errors
    apb(1'b0, 8'h05, 8'h00, 2'b00);
    check("err_rd5", {rd_err, rd_data}, 9'h100);
    apb(1'b1, 8'h04, 8'h55, 2'b00);
    check("err_wr_tcnt", rd_err, 1'b1);
    apb(1'b0, 8'h10, 8'h00, 2'b00);
    apb(1'b1, 8'h80, 8'hAA, 2'b00);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a;
      logic [1:0]    ev;
      cnt_val = 8'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(5, 255)) : AW'($urandom_range(0, 4));
      ev = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 5) == 0) pulse(2'($urandom));
      else apb(1'($urandom), a, 8'($urandom), ev);
    end

    // Reset in the middle of a transfer
    apb(1'b1, 8'h00, 8'h5A, 2'b00);
    apb(1'b1, 8'h01, 8'hB3, 2'b00);
    apb(1'b1, 8'h03, 8'h03, 2'b00);
    pulse(2'b11);
    @(posedge pclk); #1;
    psel = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hAA;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2 presetn = 1'b0;
    #1;
    model_reset();
    check("midrst_pready", pready, 1'b0);
    check("midrst_tdr", tdr, 8'h00);
    check("midrst_tcr", {tcr_load, tcr_dw, tcr_en, tcr_clksel}, 5'b0);
    check("midrst_irq", tmr_irq, 1'b0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #3 presetn = 1'b1;
    for (int i = 0; i < 5; i++) apb(1'b0, AW'(i), 8'h00, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
